// File: rtl/cpx_rsp_pkg.sv
// cpx_rsp_pkg: PCX/CPX field positions, request/return codes, FSM states and FIFO entry for cpx_rsp_stub.
package cpx_rsp_pkg;
   localparam int PCX_VLD   = 123;
   localparam int PCX_RQ_HI = 122;
   localparam int PCX_RQ_LO = 118;
   localparam int PCX_NC    = 117;
   localparam int PCX_TH_HI = 113;
   localparam int PCX_TH_LO = 112;
   localparam int PCX_AD_HI = 103;
   localparam int PCX_AD_LO = 64;
   localparam int CPX_VLD   = 144;
   localparam int CPX_RT_HI = 143;
   localparam int CPX_RT_LO = 140;
   localparam int CPX_NC    = 136;
   localparam int CPX_TH_HI = 135;
   localparam int CPX_TH_LO = 134;
   localparam int CPX_SF    = 129;
   localparam logic [4:0] LOAD_RQ   = 5'b00000;
   localparam logic [4:0] IMISS_RQ  = 5'b10000;
   localparam logic [4:0] STORE_RQ  = 5'b00001;
   localparam logic [3:0] LOAD_RET  = 4'b0000;
   localparam logic [3:0] IFILL_RET = 4'b0001;
   localparam logic [3:0] ST_ACK    = 4'b0100;
   localparam logic [7:0] LFSR_SEED = 8'hA5;
   typedef enum logic [1:0] {IDLE, WAIT, SEND, SEND2} state_t;
   typedef struct packed {
      logic [4:0]  rqtyp;
      logic        nc;
      logic [1:0]  thread;
      logic [39:0] addr;
   } fifo_entry_t;
   function automatic logic rq_supported(input logic [4:0] rq);
      return (rq == LOAD_RQ) || (rq == IMISS_RQ) || (rq == STORE_RQ);
   endfunction
endpackage

// File: rtl/cpx_rsp_fifo.sv
// cpx_rsp_fifo: DEPTH-entry synchronous FIFO of decoded PCX requests; push and pop may coincide at any count.
module cpx_rsp_fifo
   import cpx_rsp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  fifo_entry_t            i_data,
   input  logic                   i_pop,
   output fifo_entry_t            o_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);
   fifo_entry_t    r_mem [DEPTH];
   logic [AW-1:0]  r_wp, r_rp;
   logic [AW:0]    r_count;
   logic           w_pop;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rp];
   assign o_count = r_count;
   assign o_full  = r_count == (AW+1)'(DEPTH);
   assign o_empty = r_count == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wp] <= i_data;
   end
   // The grant credit scheme in the top keeps a push from ever landing on a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full && !i_pop));
endmodule

// File: rtl/cpx_rsp_stub.sv
// cpx_rsp_stub: grants PCX requests, queues supported packets and returns in-order CPX responses after LATENCY.
// Define CPX_RSP_JITTER_EN to add 0-3 cycles of LFSR-driven jitter to each response latency.
module cpx_rsp_stub
   import cpx_rsp_pkg::*;
#(
   parameter int PCX_W   = 124,
   parameter int CPX_W   = 145,
   parameter int DEPTH   = 4,
   parameter int LATENCY = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       spc_pcx_req_pq,
   input  logic [PCX_W-1:0] spc_pcx_data_pa,
   output logic [4:0]       pcx_spc_grant_px,
   output logic [CPX_W-1:0] cpx_spc_data_cx,
   output logic             rsp_busy,
   output logic [7:0]       drop_cnt
);
   localparam int CW = $clog2(LATENCY + 4) + 1;
   state_t                 r_state, w_next;
   fifo_entry_t            w_entry, w_head, r_cur;
   logic [$clog2(DEPTH):0] w_count;
   logic [4:0]             r_grant;
   logic [CW-1:0]          r_cnt, w_load;
   logic [7:0]             r_drop;
   logic [CPX_W-1:0]       w_cpx;
   logic                   r_cap, w_vld, w_sup, w_push, w_pop, w_full, w_empty, w_room, w_send, w_unused;
   assign w_vld   = r_cap && spc_pcx_data_pa[PCX_VLD];
   assign w_entry = {spc_pcx_data_pa[PCX_RQ_HI:PCX_RQ_LO], spc_pcx_data_pa[PCX_NC],
                     spc_pcx_data_pa[PCX_TH_HI:PCX_TH_LO], spc_pcx_data_pa[PCX_AD_HI:PCX_AD_LO]};
   assign w_sup   = rq_supported(w_entry.rqtyp);
   assign w_push  = w_vld && w_sup;
   assign w_pop   = (r_state == IDLE) && !w_empty;
   // r_cap marks the data cycle of the last grant, whose packet is not yet counted in the FIFO.
   assign w_room  = (int'(w_count) + int'(r_cap)) < DEPTH;
   assign w_send  = (r_state == SEND) || (r_state == SEND2);
   assign w_unused = ^{spc_pcx_data_pa, w_full};
   cpx_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant <= '0;
         r_cap   <= 1'b0;
         r_drop  <= '0;
      end else begin
         r_grant <= (~|r_grant && w_room) ? spc_pcx_req_pq : '0;
         r_cap   <= |r_grant;
         r_drop  <= r_drop + 8'(w_vld && !w_sup && r_drop != 8'hFF);
      end
   end
`ifdef CPX_RSP_JITTER_EN
   logic [7:0] r_lfsr;
   always_ff @(posedge clk) begin
      r_lfsr <= rst ? LFSR_SEED : {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
   end
   assign w_load = CW'(LATENCY) + CW'(r_lfsr[1:0]);
`else
   assign w_load = CW'(LATENCY);
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_empty ? IDLE : WAIT;
         WAIT:    w_next = (r_cnt == CW'(1)) ? SEND : WAIT;
         SEND:    w_next = (r_cur.rqtyp == IMISS_RQ) ? SEND2 : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cur   <= '0;
      end else begin
         r_state <= w_next;
         if (w_pop) begin
            r_cur <= w_head;
            r_cnt <= w_load;
         end else if (r_state == WAIT) r_cnt <= r_cnt - CW'(1);
      end
   end
   always_comb begin
      w_cpx = '0;
      if (w_send) begin
         w_cpx[CPX_VLD] = 1'b1;
         w_cpx[CPX_RT_HI:CPX_RT_LO] = (r_cur.rqtyp == LOAD_RQ) ? LOAD_RET :
                                      (r_cur.rqtyp == STORE_RQ) ? ST_ACK : IFILL_RET;
         w_cpx[CPX_NC] = r_cur.nc;
         w_cpx[CPX_TH_HI:CPX_TH_LO] = r_cur.thread;
         w_cpx[CPX_SF] = r_state == SEND2;
         // IFILL halves cover the 32-byte line: base, then base+16 on the second beat.
         w_cpx[39:0] = (r_cur.rqtyp == LOAD_RQ) ? r_cur.addr :
                       (r_cur.rqtyp == IMISS_RQ) ? {r_cur.addr[39:5], r_state == SEND2, 4'h0} : 40'h0;
      end
   end
   assign pcx_spc_grant_px = r_grant;
   assign cpx_spc_data_cx  = w_cpx;
   assign rsp_busy         = !w_empty || (r_state != IDLE);
   assign drop_cnt         = r_drop;
endmodule
